output_formatter: RTL and testbench
===================================

Name: output_formatter

Overview:
- Downstream stage of the kernel-row crossbar. Consumes the serialized, round-robin stream of signed accumulator results.
- Rounds and scales each result to a fixed-point pixel, clamps it, and tags it with start-of-frame and end-of-line markers.
- Presents the pixels as an AXI-Stream master to the output DMA/writer.
- Two-stage pipeline, full throughput, with backpressure.

Parameters:
- DATA_WIDTH, 18, width of signed input result (two's complement).
- OUT_WIDTH, 8, width of unsigned output pixel.
- FRAC_BITS, 4, fractional bits removed by rounding shift (must be >=1 and < DATA_WIDTH).
- IMG_WIDTH, 64, pixels per output line.
- IMG_HEIGHT, 64, lines per output frame.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  input result valid (from crossbar).
- s_axis_tdata  in  DATA_WIDTH  signed result.
- s_axis_tready  out  1  stage accepts input.
- m_axis_tvalid  out  1  output pixel valid.
- m_axis_tdata  out  OUT_WIDTH  unsigned pixel.
- m_axis_tuser  out  1  first pixel of frame (row 0, col 0).
- m_axis_tlast  out  1  last pixel of line (col IMG_WIDTH-1).
- frame_done  out  1  one-cycle pulse when last pixel of frame handshakes on master side.
- sat_flag  out  1  sticky: some pixel was clamped since reset/clear.
- sat_clr  in  1  synchronous clear of sat_flag.

Behaviour:
- Reset (async assert, sync-released use): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, frame_done=0, sat_flag=0. Column and row counters = 0. Stage valids = 0.
- Stage 1 (S1):
  - Register input on s handshake: sum = sext(tdata) + 2^(FRAC_BITS-1), computed at DATA_WIDTH+1 bits; no overflow possible.
  - Capture col/row tags: sof = (col==0 && row==0), eol = (col==IMG_WIDTH-1), eof = eol && (row==IMG_HEIGHT-1).
- Stage 2 (S2):
  - shifted = sum >>> FRAC_BITS (arithmetic).
  - If shifted<0 then pixel 0; if shifted>2^OUT_WIDTH-1 then pixel 2^OUT_WIDTH-1; otherwise shifted[OUT_WIDTH-1:0]. Either clamp case raises sat.
  - The S2 register drives the m_axis_* outputs directly.
- Flow control:
  - adv2 = !m_axis_tvalid || m_axis_tready.
  - adv1 = !v1 || adv2.
  - s_axis_tready = adv1 (combinational, no dependence on s_axis_tvalid).
  - S2 loads from S1 when adv2; m_axis_tvalid <= v1 on adv2.
  - S1 loads on s handshake; v1 clears when it moves to S2 with no new input.
- Latency: 2 cycles from s handshake to m_axis_tvalid. Throughput 1 pixel/cycle when m_axis_tready is held high.
- Master data and tags are stable while tvalid && !tready (AXI rule).
- Counters advance only on s handshake:
  - col wraps IMG_WIDTH-1 -> 0 and row increments.
  - row wraps IMG_HEIGHT-1 -> 0.
  - Frames are back-to-back with no idle requirement.
- frame_done: high for exactly one cycle after the master handshake of the pixel tagged eof.
- sat_flag: set when a clamped pixel loads into S2. If sat_clr and a set event occur in the same cycle, set wins.
- Reset mid-frame: all in-flight pixels are discarded and counters return to 0. The next accepted input is tagged sof.
- IMG_WIDTH=1 is legal: every pixel has tlast.

Decomposition:
- Shared package pixel_fmt_pkg: pixel type width OUT_WIDTH; constants PIX_MAX = 2^OUT_WIDTH-1 and ROUND_HALF = 2^(FRAC_BITS-1); function clog2-based counter widths.
- One sub-module, round_sat: purely combinational rounding shift plus clamp, outputting pixel and sat bit. It is instanced between S1 and S2 and tested standalone.
- Counters and the pipeline remain in the top.

Test Plan:
- Rounding (FRAC_BITS=4, OUT_WIDTH=8), tready=1:
  - Inputs 40, 24, 7, 8 -> pixels 3, 2, 0, 1.
  - Each appears 2 cycles after its input handshake.
- Clamp:
  - Inputs -20, 5000, 4087, 4088 -> pixels 0, 255, 255, 255.
  - sat_flag rises after the first clamped pixel and stays high.
  - sat_clr pulse clears it.
  - sat_clr in the same cycle as a clamp leaves it set.
- Framing (IMG_WIDTH=4, IMG_HEIGHT=2), streaming 8 pixels:
  - tuser only on pixel 0.
  - tlast on pixels 3 and 7.
  - frame_done one cycle after pixel 7's handshake.
  - The 9th pixel carries tuser again.
- Backpressure:
  - Hold m_axis_tready=0 for 5 cycles with continuous input.
  - s_axis_tready drops after 2 accepts.
  - m_axis_tdata stays stable during the stall.
  - On release, the pixel sequence is complete and in order, with no duplicates or drops.
- Random tvalid/tready (50% each), 1000 pixels:
  - Output matches the scoreboard model, including tags.
  - Throughput equals 1/cycle when both signals are held high.
- Reset at pixel 5 of the frame:
  - All outputs are 0 immediately (asynchronous).
  - After release, the first output pixel carries tuser=1, and tlast falls at col IMG_WIDTH-1 counted from the restart.

Source files
------------

// File: rtl/pixel_fmt_pkg.sv
// Shared types and constants for the output pixel formatter.
// Default widths match the standard 18-bit accumulator / 8-bit pixel path.
package pixel_fmt_pkg;

    localparam int OUT_WIDTH_DEF = 8;
    localparam int FRAC_BITS_DEF = 4;
    localparam int PIX_MAX = (1 << OUT_WIDTH_DEF) - 1;
    localparam int ROUND_HALF = 1 << (FRAC_BITS_DEF - 1);

    typedef logic [OUT_WIDTH_DEF-1:0] pixel_t;

    function automatic int pix_max(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic int round_half(input int f);
        return 1 << (f - 1);
    endfunction

    // A counter for n states needs at least one bit, even when n == 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/round_sat.sv
// Rounding arithmetic shift followed by clamp into the unsigned pixel range.
// Purely combinational; sat marks either clamp direction.
module round_sat
    import pixel_fmt_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int OUT_WIDTH  = 8,
    parameter int FRAC_BITS  = 4
) (
    input  logic signed [DATA_WIDTH:0] sum,
    output logic [OUT_WIDTH-1:0]       pixel,
    output logic                       sat
);

    logic signed [DATA_WIDTH:0] shifted;
    logic signed [DATA_WIDTH:0] max_v;

    assign shifted = sum >>> FRAC_BITS;
    assign max_v   = (DATA_WIDTH+1)'(pix_max(OUT_WIDTH));

    always_comb begin
        pixel = shifted[OUT_WIDTH-1:0];
        sat   = 1'b0;
        if (shifted < 0) begin
            pixel = '0;
            sat   = 1'b1;
        end else if (shifted > max_v) begin
            pixel = '1;
            sat   = 1'b1;
        end
    end

endmodule

// File: rtl/output_formatter.sv
// Two-stage round/clamp/tag pipeline presenting pixels as an AXI-Stream master.
// Frame position counters advance only on accepted input beats.
module output_formatter
    import pixel_fmt_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int OUT_WIDTH  = 8,
    parameter int FRAC_BITS  = 4,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [OUT_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  frame_done,
    output logic                  sat_flag,
    input  logic                  sat_clr
);

    localparam int COL_W = cnt_w(IMG_WIDTH);
    localparam int ROW_W = cnt_w(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [DATA_WIDTH:0] HALF = (DATA_WIDTH+1)'(round_half(FRAC_BITS));

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic                   v1;
    logic [DATA_WIDTH:0]    s1_sum;
    logic                   s1_sof;
    logic                   s1_eol;
    logic                   s1_eof;
    logic                   s2_eof;

    logic                   adv1;
    logic                   adv2;
    logic                   s_hs;
    logic                   m_hs;
    logic [OUT_WIDTH-1:0]   pix;
    logic                   pix_sat;
    logic                   sat_set;

    assign adv2          = !m_axis_tvalid || m_axis_tready;
    assign adv1          = !v1 || adv2;
    assign s_axis_tready = adv1;
    assign s_hs          = s_axis_tvalid && adv1;
    assign m_hs          = m_axis_tvalid && m_axis_tready;
    assign sat_set       = adv2 && v1 && pix_sat;

    round_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_round_sat (
        .sum   ($signed(s1_sum)),
        .pixel (pix),
        .sat   (pix_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (s_hs) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            s1_sum <= '0;
            s1_sof <= 1'b0;
            s1_eol <= 1'b0;
            s1_eof <= 1'b0;
        end else if (adv1) begin
            v1 <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                s1_sum <= {s_axis_tdata[DATA_WIDTH-1], s_axis_tdata} + HALF;
                s1_sof <= (col == '0) && (row == '0);
                s1_eol <= (col == COL_LAST);
                s1_eof <= (col == COL_LAST) && (row == ROW_LAST);
            end
        end
    end

    // Payload only loads with a valid beat so stalled data never changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            s2_eof        <= 1'b0;
        end else if (adv2) begin
            m_axis_tvalid <= v1;
            if (v1) begin
                m_axis_tdata <= pix;
                m_axis_tuser <= s1_sof;
                m_axis_tlast <= s1_eol;
                s2_eof       <= s1_eof;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            frame_done <= m_hs && s2_eof;
            if (sat_set) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_output_formatter.sv
// Directed and random stimulus for output_formatter with a queue scoreboard.
// Also exercises round_sat on its own.
module tb_output_formatter;

    localparam int DW = 18;
    localparam int OW = 8;
    localparam int FB = 4;
    localparam int IW = 4;
    localparam int IH = 2;

    typedef struct {
        logic [OW-1:0] data;
        logic          user;
        logic          last;
        logic          eof;
        int            t;
    } item_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_axis_tvalid = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tready;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [OW-1:0] m_axis_tdata;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          frame_done;
    logic          sat_flag;
    logic          sat_clr = 1'b0;

    logic signed [DW:0] rs_sum = '0;
    logic [OW-1:0]      rs_pix;
    logic               rs_sat;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    mcol = 0;
    int    mrow = 0;
    int    fd_cnt = 0;
    bit    lat_chk = 0;
    bit    fd_exp = 0;
    bit    prev_stall = 0;
    bit    last_in_hs = 0;
    bit    last_out_hs = 0;
    logic [OW+1:0] prev_out = '0;
    item_t q[$];

    output_formatter #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .FRAC_BITS  (FB),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .frame_done    (frame_done),
        .sat_flag      (sat_flag),
        .sat_clr       (sat_clr)
    );

    round_sat #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .FRAC_BITS  (FB)
    ) u_rs (
        .sum   (rs_sum),
        .pixel (rs_pix),
        .sat   (rs_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: floor((x + 8) / 16), then clamp to 0..255.
    function automatic logic [OW-1:0] model_pix(input int x);
        int s;
        s = (x + (1 << (FB - 1))) >>> FB;
        if (s < 0) return '0;
        if (s > (1 << OW) - 1) return '1;
        return s[OW-1:0];
    endfunction

    task automatic monitor();
        item_t it;
        cyc++;
        last_in_hs  = 0;
        last_out_hs = 0;
        if (rst) begin
            fd_exp     = 0;
            prev_stall = 0;
            return;
        end
        chk("frame_done", 32'(frame_done), 32'(fd_exp));
        if (frame_done) fd_cnt++;
        fd_exp = 0;
        if (prev_stall && m_axis_tvalid)
            chk("stall_stable",
                32'({m_axis_tdata, m_axis_tuser, m_axis_tlast}),
                32'(prev_out));
        if (m_axis_tvalid && m_axis_tready) begin
            last_out_hs = 1;
            if (q.size() == 0) begin
                chk("sb_underflow", 32'(q.size()), 1);
            end else begin
                it = q.pop_front();
                chk("tdata", 32'(m_axis_tdata), 32'(it.data));
                chk("tuser", 32'(m_axis_tuser), 32'(it.user));
                chk("tlast", 32'(m_axis_tlast), 32'(it.last));
                if (lat_chk) chk("latency", 32'(cyc - it.t), 2);
                if (it.eof) fd_exp = 1;
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out   = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        if (s_axis_tvalid && s_axis_tready) begin
            last_in_hs = 1;
            it.data = model_pix(int'($signed(s_axis_tdata)));
            it.user = (mcol == 0) && (mrow == 0);
            it.last = (mcol == IW - 1);
            it.eof  = it.last && (mrow == IH - 1);
            it.t    = cyc;
            q.push_back(it);
            if (mcol == IW - 1) begin
                mcol = 0;
                mrow = (mrow == IH - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = x[DW-1:0];
        for (int i = 0; i < 200; i++) begin
            step();
            if (last_in_hs) return;
        end
        chk("send_timeout", 32'(last_in_hs), 1);
    endtask

    task automatic drain();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (q.size() == 0 && !m_axis_tvalid) return;
            step();
        end
        chk("drain_timeout", 32'(q.size()), 0);
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        q.delete();
        mcol = 0;
        mrow = 0;
    endtask

    initial begin
        int acc;
        int v;
        int sent;
        int outs;

        // Standalone rounding/clamp unit.
        rs_sum = 19'sd48;   #1;
        chk("rs_pix_48", 32'(rs_pix), 3);
        chk("rs_sat_48", 32'(rs_sat), 0);
        rs_sum = -19'sd12;  #1;
        chk("rs_pix_neg", 32'(rs_pix), 0);
        chk("rs_sat_neg", 32'(rs_sat), 1);
        rs_sum = 19'sd4096; #1;
        chk("rs_pix_over", 32'(rs_pix), 255);
        chk("rs_sat_over", 32'(rs_sat), 1);
        rs_sum = 19'sd4095; #1;
        chk("rs_pix_max", 32'(rs_pix), 255);
        chk("rs_sat_max", 32'(rs_sat), 0);

        step();
        step();
        chk("rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_tdata", 32'(m_axis_tdata), 0);
        chk("rst_tuser", 32'(m_axis_tuser), 0);
        chk("rst_tlast", 32'(m_axis_tlast), 0);
        chk("rst_fdone", 32'(frame_done), 0);
        chk("rst_sat", 32'(sat_flag), 0);
        rst = 1'b0;
        step();

        // Rounding with latency check.
        lat_chk = 1;
        send(40);
        send(24);
        send(7);
        send(8);
        drain();
        lat_chk = 0;
        chk("sat_after_round", 32'(sat_flag), 0);

        // Clamping and sticky flag.
        send(-20);
        drain();
        chk("sat_set", 32'(sat_flag), 1);
        send(5000);
        send(4087);
        send(4088);
        drain();
        chk("sat_sticky", 32'(sat_flag), 1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("sat_clr", 32'(sat_flag), 0);
        send(-20);
        s_axis_tvalid = 1'b0;
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("sat_set_wins", 32'(sat_flag), 1);
        drain();

        // Framing: 9 pixels, one full frame plus one.
        do_reset();
        fd_cnt = 0;
        for (int i = 0; i < 9; i++) send(i * 16 + 8);
        drain();
        chk("fd_count", 32'(fd_cnt), 1);

        // Backpressure with continuous input.
        m_axis_tready = 1'b0;
        acc = 0;
        v = 1000;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = DW'(v);
        for (int i = 0; i < 5; i++) begin
            step();
            if (last_in_hs) begin
                acc++;
                v += 16;
                s_axis_tdata = DW'(v);
            end
        end
        chk("bp_accepts", 32'(acc), 2);
        chk("bp_sready", 32'(s_axis_tready), 0);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (last_in_hs) begin
                v += 16;
                s_axis_tdata = DW'(v);
            end
        end
        drain();

        // Full throughput with both sides held high.
        outs = 0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata = DW'(i * 37);
            step();
            if (i >= 4 && last_out_hs) outs++;
        end
        chk("throughput", 32'(outs), 16);
        drain();

        // Random valid/ready.
        sent = 0;
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 20000 && sent < 1000; i++) begin
            if (!s_axis_tvalid || last_in_hs) begin
                s_axis_tvalid = ($urandom_range(0, 1) == 1);
                v = int'($urandom_range(0, 6000)) - 1000;
                s_axis_tdata = v[DW-1:0];
            end
            m_axis_tready = ($urandom_range(0, 1) == 1);
            step();
            if (last_in_hs) sent++;
        end
        chk("rand_sent", 32'(sent), 1000);
        drain();

        // Asynchronous reset mid-frame.
        do_reset();
        for (int i = 0; i < 5; i++) send(i * 16 + 100);
        s_axis_tvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tvalid", 32'(m_axis_tvalid), 0);
        chk("arst_tdata", 32'(m_axis_tdata), 0);
        chk("arst_tuser", 32'(m_axis_tuser), 0);
        chk("arst_tlast", 32'(m_axis_tlast), 0);
        chk("arst_fdone", 32'(frame_done), 0);
        chk("arst_sat", 32'(sat_flag), 0);
        q.delete();
        mcol = 0;
        mrow = 0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send(i * 16 + 300);
        drain();

        chk("sb_empty_end", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
